mem_access_unit: RTL

//  Parametrised memory-access unit for the multi-cycle data path. Replaces the fixed 32-bit RAM/MOC

---
 rtl/mem_access_unit_pkg.sv | 20 ++
 rtl/mem_access_unit_if.sv | 26 ++
 rtl/mem_access_unit_mem_byte_array.sv | 38 +++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared size encodings and FSM state codes for the memory-access unit
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        DL_BYTE = 2'b00,
        DL_HALF = 2'b01,
        DL_WORD = 2'b10,
        DL_RSVD = 2'b11
    } dl_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    // The datum never exceeds a 32-bit word, so four byte lanes always suffice.
    localparam int LANES = 4;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - req/moc access bus between MAR/MDR control and the memory-access unit
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              req;
    logic              rw;
    logic              sig;
    logic [1:0]        dl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              moc;
    logic              busy;
    logic              err;

    modport master (
        output req, rw, sig, dl, addr, wdata,
        input  rdata, moc, busy, err
    );

    modport slave (
        input  req, rw, sig, dl, addr, wdata,
        output rdata, moc, busy, err
    );
endinterface

// File: rtl/mem_access_unit_mem_byte_array.sv
// rtl/mem_access_unit_mem_byte_array.sv - byte storage with synchronous lane writes and combinational lane reads
module mem_byte_array #(
    parameter int MEM_BYTES = 512,
    parameter int ADDR_W    = 9,
    parameter int LANES     = 4
) (
    input  logic                 clk,
    input  logic [ADDR_W-1:0]    base,
    input  logic [LANES-1:0]     we,
    input  logic [LANES*8-1:0]   wdata,
    output logic [LANES*8-1:0]   rdata
);
    localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    logic [7:0]       mem [MEM_BYTES];
    logic [IDX_W-1:0] lane_idx [LANES];

    // Lane i addresses byte base+i, wrapped so a datum can straddle the top of storage.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_idx[i] = IDX_W'((32'(base) + 32'(i)) % 32'(MEM_BYTES));
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            rdata[8*i +: 8] = mem[lane_idx[i]];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem[lane_idx[i]] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - big-endian byte/half/word access unit with wait states and sign extension
// Define ALIGN_CHECK_EN to reject half/word accesses at addresses not a multiple of their size.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int MEM_BYTES   = 512,
    parameter int WAIT_STATES = 1
) (
    input  logic              main_clk,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);
    state_e            state_q, state_d;
    logic              l_rw, l_sig;
    dl_e               l_dl;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              wait_done, do_access, misaligned, reject;
    logic [LANES-1:0]  mask, lane_we;
    logic [LANES*8-1:0] lane_wdata, rd_lanes;
    logic [DATA_W-1:0] rd_ext;
    logic              sign;

    assign wait_done = (cnt == 4'(WAIT_STATES));
    assign do_access = (state_q == ST_ACCESS) && wait_done;

`ifdef ALIGN_CHECK_EN
    assign misaligned = ((l_dl == DL_HALF) && l_addr[0]) ||
                        ((l_dl == DL_WORD) && (l_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif
    assign reject = (l_dl == DL_RSVD) || misaligned;

    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.req)   state_d = ST_ACCESS;
            ST_ACCESS: if (wait_done) state_d = ST_DONE;
            ST_DONE:   if (!bus.req)  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Lane 0 is the lowest address and carries the most-significant byte of the datum.
    always_comb begin
        sign       = l_sig & rd_lanes[7];
        rd_ext     = {DATA_W{sign}};
        lane_wdata = '0;
        mask       = '0;
        case (l_dl)
            DL_BYTE: begin
                mask          = 4'b0001;
                lane_wdata[7:0] = l_wdata[7:0];
                rd_ext[7:0]   = rd_lanes[7:0];
            end
            DL_HALF: begin
                mask          = 4'b0011;
                lane_wdata[15:0] = {l_wdata[7:0], l_wdata[15:8]};
                rd_ext[15:0]  = {rd_lanes[7:0], rd_lanes[15:8]};
            end
            DL_WORD: begin
                mask          = 4'b1111;
                lane_wdata    = {l_wdata[7:0], l_wdata[15:8], l_wdata[23:16], l_wdata[31:24]};
                rd_ext[31:0]  = {rd_lanes[7:0], rd_lanes[15:8], rd_lanes[23:16], rd_lanes[31:24]};
            end
            default: mask = '0;
        endcase
        lane_we = (do_access && !l_rw && !reject) ? mask : '0;
    end

    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            l_rw    <= 1'b0;
            l_sig   <= 1'b0;
            l_dl    <= DL_BYTE;
            l_addr  <= '0;
            l_wdata <= '0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && bus.req) begin
                l_rw    <= bus.rw;
                l_sig   <= bus.sig;
                l_dl    <= dl_e'(bus.dl);
                l_addr  <= bus.addr;
                l_wdata <= bus.wdata;
                cnt     <= '0;
            end
            if ((state_q == ST_ACCESS) && !wait_done) begin
                cnt <= cnt + 4'd1;
            end
            if (do_access) begin
                err_q <= reject;
                if (l_rw && !reject) begin
                    rdata_q <= rd_ext;
                end
            end
            if ((state_q == ST_DONE) && !bus.req) begin
                err_q <= 1'b0;
            end
        end
    end

    mem_byte_array #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W),
        .LANES     (LANES)
    ) u_mem (
        .clk   (main_clk),
        .base  (l_addr),
        .we    (lane_we),
        .wdata (lane_wdata),
        .rdata (rd_lanes)
    );

    assign bus.rdata = rdata_q;
    assign bus.moc   = (state_q == ST_DONE);
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.err   = err_q;
endmodule
